// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic WR    = 1'b0;
   localparam logic RD    = 1'b1;
   localparam int   MAX_N = 8;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational winner select: round-robin from ptr when I2C_ARB_RR_EN is defined,
// otherwise fixed priority (lowest index wins, no ptr port).
module i2c_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
`ifdef I2C_ARB_RR_EN
   input  logic [IDX_W-1:0] ptr,
`endif
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   assign any = |req;

`ifdef I2C_ARB_RR_EN
   logic             found;
   logic [IDX_W-1:0] pos;

   // Walk N slots starting at ptr; first requester seen wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IDX_W'((int'(ptr) + k) % N);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end
`else
   logic             found;
   logic [IDX_W-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IDX_W'(k);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end
`endif

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C byte controller among N requesters; grant held for the whole transaction.
// Overhead 3 cycles plus controller time; I2C_ARB_RR_EN selects round-robin over fixed priority.
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         s_valid,
   output logic [N-1:0]         s_ready,
   input  logic [N-1:0]         s_direct,
   input  logic [8*N-1:0]       s_addr,
   input  logic [8*N-1:0]       s_din,
   output logic [N-1:0]         s_done,
   output logic [7:0]           s_rdata,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_direct,
   output logic [7:0]           m_addr,
   output logic [7:0]           m_din,
   input  logic [7:0]           m_dout,
   output logic                 busy,
   output logic [$clog2(N)-1:0] owner,
   output logic [CNT_W-1:0]     txn_cnt
);

   localparam int IDX_W = $clog2(N);

   state_t           state;
   state_t           state_nxt;
   logic             grab;
   logic [N-1:0]     pick_grant;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [N-1:0]     owner_oh;

`ifdef I2C_ARB_RR_EN
   logic [IDX_W-1:0] ptr;
`endif

   i2c_rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (s_valid),
`ifdef I2C_ARB_RR_EN
      .ptr   (ptr),
`endif
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign owner_oh = N'(1) << owner;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // m_valid is only high in ISSUE, so m_ready alone marks the handshake there.
   always_comb begin
      state_nxt = state;
      grab      = 1'b0;
      case (state)
         IDLE: begin
            if (m_ready && pick_any) begin
               grab      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   if (m_ready) state_nxt = BUSY;
         BUSY:    if (m_ready) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready  <= '0;
         s_done   <= '0;
         s_rdata  <= '0;
         m_valid  <= 1'b0;
         m_direct <= WR;
         m_addr   <= '0;
         m_din    <= '0;
         owner    <= '0;
         txn_cnt  <= '0;
`ifdef I2C_ARB_RR_EN
         ptr      <= '0;
`endif
      end else begin
         s_ready <= '0;
         s_done  <= '0;
         case (state)
            IDLE: begin
               if (grab) begin
                  owner    <= pick_idx;
                  s_ready  <= pick_grant;
                  m_valid  <= 1'b1;
                  m_direct <= s_direct[pick_idx];
                  m_addr   <= s_addr[{pick_idx, 3'b000} +: 8];
                  m_din    <= s_din[{pick_idx, 3'b000} +: 8];
               end
            end
            ISSUE: begin
               if (m_ready) m_valid <= 1'b0;
            end
            BUSY: begin
               if (m_ready) begin
                  s_rdata <= m_dout;
                  s_done  <= owner_oh;
               end
            end
            DONE: begin
               txn_cnt <= txn_cnt + CNT_W'(1);
`ifdef I2C_ARB_RR_EN
               ptr     <= (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: controller model, directed scenarios and a randomized run.
module tb_i2c_req_arbiter;
   import i2c_arb_pkg::*;

   localparam int N     = 4;
   localparam int CNT_W = 8;
   localparam int IW    = $clog2(N);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     s_valid = '0;
   logic [N-1:0]     s_ready;
   logic [N-1:0]     s_direct = '0;
   logic [8*N-1:0]   s_addr = '0;
   logic [8*N-1:0]   s_din = '0;
   logic [N-1:0]     s_done;
   logic [7:0]       s_rdata;
   logic             m_valid;
   logic             m_ready;
   logic             m_direct;
   logic [7:0]       m_addr;
   logic [7:0]       m_din;
   logic [7:0]       m_dout;
   logic             busy;
   logic [IW-1:0]    owner;
   logic [CNT_W-1:0] txn_cnt;

   i2c_req_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_direct(s_direct),
      .s_addr(s_addr), .s_din(s_din), .s_done(s_done), .s_rdata(s_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_direct(m_direct),
      .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
      .busy(busy), .owner(owner), .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int ctl_lat  = 2;
   bit ctl_hold = 1'b0;
   int ptr_m    = 0;
   int cnt_m    = 0;
   int stab_viol = 0;
   int ovl_viol  = 0;
   int rdy_cnt[N];
   int done_cnt[N];

   // Controller: accepts when idle, returns addr^0x4A after ctl_lat cycles.
   initial begin : ctl_model
      int   cnt;
      bit   acc;
      bit   rs;
      logic [7:0] a;
      logic [7:0] resp;
      cnt = 0; resp = '0;
      m_ready = 1'b0; m_dout = '0;
      forever begin
         @(negedge clk);
         acc = m_valid && m_ready;
         a   = m_addr;
         rs  = rst;
         @(posedge clk); #1;
         if (rs) begin
            cnt = 0; m_ready = !ctl_hold;
         end else if (acc) begin
            m_ready = 1'b0; cnt = ctl_lat; resp = a ^ 8'h4A;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin m_ready = 1'b1; m_dout = resp; end
         end else begin
            m_ready = !ctl_hold;
         end
      end
   end

   initial begin : monitor
      logic [7:0] ha, hd;
      logic       hr;
      bit         pb;
      pb = 1'b0; ha = '0; hd = '0; hr = 1'b0;
      for (int i = 0; i < N; i++) begin rdy_cnt[i] = 0; done_cnt[i] = 0; end
      forever begin
         @(negedge clk);
         if ((s_ready & s_done) != '0) ovl_viol++;
         if (busy && pb && (m_addr !== ha || m_din !== hd || m_direct !== hr)) stab_viol++;
         ha = m_addr; hd = m_din; hr = m_direct; pb = busy;
         for (int i = 0; i < N; i++) begin
            if (s_ready[i]) rdy_cnt[i]++;
            if (s_done[i])  done_cnt[i]++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   function automatic int exp_winner(input logic [N-1:0] req, input int ptr);
      int base;
      base = ptr;
`ifndef I2C_ARB_RR_EN
      base = 0;
`endif
      for (int k = 0; k < N; k++)
         if (req[(base + k) % N]) return (base + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0 && i < N) v[i] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; s_valid = '0; s_direct = '0; s_addr = '0; s_din = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cnt_m = 0; ptr_m = 0;
   endtask

   task automatic set_req(input int i, input logic d, input logic [7:0] a, input logic [7:0] w);
      s_valid[i] = 1'b1; s_direct[i] = d;
      s_addr[i*8 +: 8] = a; s_din[i*8 +: 8] = w;
   endtask

   // sel=0 waits for s_ready, sel=1 for s_done; v stays 0 if the budget expires.
   task automatic wait_pulse(input int sel, input int budget, output logic [N-1:0] v, output int n);
      v = '0; n = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (sel == 0 && s_ready != '0) begin v = s_ready; break; end
         if (sel == 1 && s_done  != '0) begin v = s_done;  break; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({s_ready, s_done, m_valid, busy} !== '0) begin
         failures++; $display("FAIL reset_ctl: got %0h expected 0", {s_ready, s_done, m_valid, busy});
      end
      checks++;
      if ({m_direct, m_addr, m_din} !== '0) begin
         failures++; $display("FAIL reset_m: got %0h expected 0", {m_direct, m_addr, m_din});
      end
      checks++;
      if ({s_rdata, owner, txn_cnt} !== '0) begin
         failures++; $display("FAIL reset_regs: got %0h expected 0", {s_rdata, owner, txn_cnt});
      end
   endtask

   task automatic test_single_read();
      logic [N-1:0] v;
      int n, r0, d0;
      ctl_lat = 40;
      @(posedge clk); #1;
      r0 = rdy_cnt[2]; d0 = done_cnt[2];
      set_req(2, RD, 8'h10, 8'h00);
      wait_pulse(0, 10, v, n);
      checks++;
      if (v !== 4'b0100 || n != 2 || m_valid !== 1'b1) begin
         failures++; $display("FAIL read_grant: got rdy=%b after %0d m_valid=%b expected 0100 after 2 m_valid=1", v, n, m_valid);
      end
      checks++;
      if (m_addr !== 8'h10 || m_direct !== RD || owner !== IW'(2)) begin
         failures++; $display("FAIL read_issue: got addr=%h dir=%b owner=%0d expected 10 1 2", m_addr, m_direct, owner);
      end
      @(posedge clk); #1 s_valid[2] = 1'b0;
      wait_pulse(1, 200, v, n);
      checks++;
      if (v !== 4'b0100 || n != 42) begin
         failures++; $display("FAIL read_done: got done=%b after %0d expected 0100 after 42", v, n);
      end
      checks++;
      if (s_rdata !== 8'h5A) begin
         failures++; $display("FAIL read_data: got %h expected 5a", s_rdata);
      end
      cnt_m++; ptr_m = 3 % N;
      @(negedge clk);
      checks++;
      if (txn_cnt !== CNT_W'(cnt_m) || s_done !== '0) begin
         failures++; $display("FAIL read_cnt: got cnt=%0d done=%b expected %0d 0000", txn_cnt, s_done, cnt_m);
      end
      checks++;
      if (rdy_cnt[2] - r0 != 1 || done_cnt[2] - d0 != 1) begin
         failures++; $display("FAIL read_pulses: got rdy=%0d done=%0d expected 1 1", rdy_cnt[2] - r0, done_cnt[2] - d0);
      end
   endtask

   task automatic test_init_wait();
      logic [N-1:0] v;
      int n, bad;
      ctl_hold = 1'b1; ctl_lat = 3;
      do_reset();
      set_req(0, WR, 8'h22, 8'h33);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (s_ready != '0 || m_valid) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL init_hold: got %0d grant cycles expected 0", bad);
      end
      ctl_hold = 1'b0;
      wait_pulse(0, 10, v, n);
      checks++;
      if (v !== 4'b0001 || n != 2) begin
         failures++; $display("FAIL init_grant: got rdy=%b after %0d expected 0001 after 2", v, n);
      end
      @(posedge clk); #1 s_valid[0] = 1'b0;
      wait_pulse(1, 50, v, n);
      checks++;
      if (v !== 4'b0001) begin
         failures++; $display("FAIL init_done: got %b expected 0001", v);
      end
      cnt_m++; ptr_m = 1;
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      logic [N-1:0] v, all;
      int n, w;
      ctl_lat = 3;
      all = '1;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, RD, 8'(8'h30 + i), 8'h00);
      wait_pulse(0, 10, v, n);
      for (int k = 0; k < 8; k++) begin
         w = exp_winner(all, ptr_m);
         checks++;
         if (v !== onehot(w)) begin
            failures++; $display("FAIL arb_order%0d: got %b expected %b", k, v, onehot(w));
         end
         wait_pulse(1, 50, v, n);
         checks++;
         if (v !== onehot(w) || s_rdata !== (8'(8'h30 + w) ^ 8'h4A)) begin
            failures++; $display("FAIL arb_done%0d: got %b/%h expected %b/%h", k, v, s_rdata, onehot(w), 8'(8'h30 + w) ^ 8'h4A);
         end
         cnt_m++; ptr_m = (w + 1) % N;
         if (k < 7) begin
            wait_pulse(0, 10, v, n);
            checks++;
            if (n != 2) begin
               failures++; $display("FAIL b2b_gap%0d: got %0d cycles expected 2", k, n);
            end
         end
      end
      @(posedge clk); #1 s_valid = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (txn_cnt !== CNT_W'(cnt_m) || busy !== 1'b0) begin
         failures++; $display("FAIL arb_cnt: got %0d busy=%b expected %0d 0", txn_cnt, busy, cnt_m);
      end
   endtask

   task automatic test_write_stable();
      logic [N-1:0] v;
      int n, bad, d[N];
      ctl_lat = 6;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) d[i] = done_cnt[i];
      set_req(1, WR, 8'h03, 8'hA7);
      wait_pulse(0, 10, v, n);
      checks++;
      if (v !== 4'b0010 || m_din !== 8'hA7 || m_direct !== WR || m_addr !== 8'h03) begin
         failures++; $display("FAIL wr_issue: got rdy=%b din=%h dir=%b addr=%h expected 0010 a7 0 03", v, m_din, m_direct, m_addr);
      end
      @(posedge clk); #1 s_valid[1] = 1'b0;
      bad = 0; v = '0; n = 0;
      while (n < 50 && v == '0) begin
         @(negedge clk);
         n++;
         if (m_din !== 8'hA7 || m_direct !== WR || m_addr !== 8'h03) bad++;
         v = s_done;
      end
      checks++;
      if (v !== 4'b0010 || bad != 0) begin
         failures++; $display("FAIL wr_stable: got done=%b unstable=%0d expected 0010 0", v, bad);
      end
      cnt_m++; ptr_m = 2;
      @(negedge clk);
      checks++;
      if (done_cnt[0] != d[0] || done_cnt[2] != d[2] || done_cnt[3] != d[3] || done_cnt[1] != d[1] + 1) begin
         failures++; $display("FAIL wr_others: got %0d/%0d/%0d/%0d extra dones expected 0/1/0/0",
            done_cnt[0] - d[0], done_cnt[1] - d[1], done_cnt[2] - d[2], done_cnt[3] - d[3]);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] v;
      int n, d3;
      ctl_lat = 20;
      @(posedge clk); #1;
      set_req(3, RD, 8'h44, 8'h00);
      wait_pulse(0, 10, v, n);
      @(posedge clk); #1 s_valid[3] = 1'b0;
      repeat (3) @(negedge clk);
      d3 = done_cnt[3];
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({s_ready, s_done, m_valid, busy, m_direct, m_addr, m_din} !== '0) begin
         failures++; $display("FAIL midrst_out: got %0h expected 0", {s_ready, s_done, m_valid, busy, m_direct, m_addr, m_din});
      end
      checks++;
      if ({s_rdata, owner, txn_cnt} !== '0) begin
         failures++; $display("FAIL midrst_regs: got %0h expected 0", {s_rdata, owner, txn_cnt});
      end
      @(posedge clk); #1 rst = 1'b0;
      cnt_m = 0; ptr_m = 0;
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt[3] != d3) begin
         failures++; $display("FAIL midrst_nodone: got %0d dones expected 0", done_cnt[3] - d3);
      end
      ctl_lat = 5;
      @(posedge clk); #1;
      set_req(3, RD, 8'h44, 8'h00);
      wait_pulse(0, 10, v, n);
      @(posedge clk); #1 s_valid[3] = 1'b0;
      wait_pulse(1, 50, v, n);
      checks++;
      if (v !== 4'b1000 || s_rdata !== 8'h0E) begin
         failures++; $display("FAIL midrst_fresh: got %b/%h expected 1000/0e", v, s_rdata);
      end
      cnt_m++; ptr_m = 0;
      @(negedge clk);
      checks++;
      if (txn_cnt !== CNT_W'(cnt_m)) begin
         failures++; $display("FAIL midrst_cnt: got %0d expected %0d", txn_cnt, cnt_m);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] prev, drop;
      logic [7:0]   exp_addr;
      logic         exp_dir;
      int own, w, grants, dones, bad_win, bad_addr, bad_done, bad_data;
      bit inflight, gen;
      do_reset();
      drop = '0; own = 0; inflight = 0; exp_addr = '0; exp_dir = WR;
      grants = 0; dones = 0; bad_win = 0; bad_addr = 0; bad_done = 0; bad_data = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         gen = (cyc < 1200);
         @(posedge clk); #1;
         prev = s_valid;
         for (int i = 0; i < N; i++) begin
            if (drop[i] || !gen) begin
               s_valid[i] = 1'b0; drop[i] = 1'b0;
            end else if (s_valid[i] && $urandom_range(0, 15) == 0) begin
               s_valid[i] = 1'b0;
            end else if (!s_valid[i] && $urandom_range(0, 3) == 0) begin
               set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
            end
         end
         @(negedge clk);
         if (s_ready != '0) begin
            grants++;
            w = exp_winner(prev, ptr_m);
            if (w < 0 || inflight || s_ready !== onehot(w)) bad_win++;
            else begin
               exp_addr = s_addr[w*8 +: 8];
               exp_dir  = s_direct[w];
               if (m_addr !== exp_addr || m_direct !== exp_dir || m_din !== s_din[w*8 +: 8]) bad_addr++;
               inflight = 1; drop[w] = 1'b1; own = w;
            end
         end
         if (s_done != '0) begin
            dones++;
            if (!inflight || s_done !== onehot(own)) bad_done++;
            else if (exp_dir == RD && s_rdata !== (exp_addr ^ 8'h4A)) bad_data++;
            inflight = 0; cnt_m++; ptr_m = (own + 1) % N;
         end
         ctl_lat = $urandom_range(1, 5);
      end
      checks++;
      if (bad_win != 0 || bad_addr != 0) begin
         failures++; $display("FAIL rnd_grant: got %0d wrong winners %0d wrong latches expected 0 0", bad_win, bad_addr);
      end
      checks++;
      if (bad_done != 0 || bad_data != 0) begin
         failures++; $display("FAIL rnd_done: got %0d wrong dones %0d wrong data expected 0 0", bad_done, bad_data);
      end
      checks++;
      if (grants != dones || grants < 20 || inflight) begin
         failures++; $display("FAIL rnd_count: got grants=%0d dones=%0d expected equal and >=20", grants, dones);
      end
      checks++;
      if (txn_cnt !== CNT_W'(cnt_m)) begin
         failures++; $display("FAIL rnd_txn: got %0d expected %0d", txn_cnt, CNT_W'(cnt_m));
      end
      checks++;
      if (stab_viol != 0 || ovl_viol != 0) begin
         failures++; $display("FAIL protocol: got %0d unstable %0d overlap expected 0 0", stab_viol, ovl_viol);
      end
   endtask

   task automatic test_wrap();
      logic [N-1:0] v;
      logic [CNT_W-1:0] all_ones;
      int n, lost;
      all_ones = '1;
      ctl_lat = 1;
      do_reset();
      lost = 0;
      for (int i = 0; i < (1 << CNT_W); i++) begin
         @(posedge clk); #1;
         set_req(0, WR, 8'($urandom), 8'($urandom));
         wait_pulse(0, 10, v, n);
         @(posedge clk); #1 s_valid[0] = 1'b0;
         wait_pulse(1, 20, v, n);
         if (v !== 4'b0001) lost++;
         cnt_m++;
         @(negedge clk);
         if (i == (1 << CNT_W) - 2) begin
            checks++;
            if (txn_cnt !== all_ones) begin
               failures++; $display("FAIL wrap_max: got %h expected %h", txn_cnt, all_ones);
            end
         end
      end
      checks++;
      if (txn_cnt !== '0 || lost != 0) begin
         failures++; $display("FAIL wrap_zero: got %h lost=%0d expected 0 0", txn_cnt, lost);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_init_wait();
      test_arbitration();
      test_write_stable();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Shares one I2C byte-transaction controller (the valid/ready, direct, addr, din, dout port in front of the APB-attached I2C master) among N independent requesters. Each granted request is held for the controller's full transaction. Completion is reported back to the owning requester with read data. Sits between the system-side clients (sensor pollers, config loaders) and the single I2C controller instance.

## Interface
- N, 4: number of requesters, 2..8
- CNT_W, 16: width of transaction counter
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  N  per-requester request valid; held until s_ready
- s_ready  out  N  one-hot, one-cycle accept pulse
- s_direct  in  N  per-requester direction, 0=write, 1=read
- s_addr  in  8*N  register address, requester i at [8i+7:8i]
- s_din  in  8*N  write data, same packing
- s_done  out  N  one-hot, one-cycle completion pulse
- s_rdata  out  8  read data, valid with s_done (write: last captured value)
- m_valid  out  1  request to controller
- m_ready  in  1  controller idle/accept (low during controller init and while busy)
- m_direct  out  1  direction to controller
- m_addr  out  8  address to controller
- m_din  out  8  write data to controller
- m_dout  in  8  read data from controller, valid when m_ready re-rises
- busy  out  1  high in any state except IDLE
- owner  out  $clog2(N)  index of current/last granted requester
- txn_cnt  out  CNT_W  completed transactions, wraps

## Operation
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE: if m_ready=1 and any s_valid, pick winner w and latch s_direct/s_addr/s_din[w] into m_* regs. Set owner=w, s_ready[w]=1 (registered) and go to ISSUE. If m_ready=0, wait; requests stay pending.
- ISSUE: m_valid=1, s_ready[owner]=1 for this cycle only. At the edge where m_valid&m_ready, deassert m_valid and go to BUSY. If m_ready=0, hold m_valid and stay in ISSUE; s_ready is not repeated.
- BUSY: wait for m_ready=1. Then capture m_dout into s_rdata and go to DONE.
- DONE: s_done[owner]=1 for one cycle, txn_cnt+1 (wraps at 2^CNT_W-1 to 0), update priority pointer, go to IDLE.
- m_addr/m_din/m_direct are stable from ISSUE through DONE.
- Arbitration change only in IDLE. A requester dropping s_valid before its s_ready is legal: it is not granted if low in the IDLE sampling cycle.
- Reset values: state IDLE, s_ready=0, s_done=0, m_valid=0, m_direct/m_addr/m_din=0, s_rdata=0, busy=0, owner=0, txn_cnt=0, pointer=0.
- Reset mid-transaction: immediate return to IDLE; no s_done issued. The controller shares rst, so no recovery is needed.

## Timing
- Request in IDLE at cycle 0 (m_ready=1): s_ready and m_valid are high in cycle 1. BUSY starts at cycle 2. s_done is high 1 cycle after m_ready re-rises.
- Arbiter overhead per transaction: 3 cycles (IDLE, ISSUE, DONE) plus controller time.
- Back-to-back: the next grant is decided in the IDLE cycle following DONE.
- s_ready and s_done are never high in the same cycle for the same requester.

## Configuration
- I2C_ARB_RR_EN defined: round-robin. The search starts at pointer; in DONE, pointer = owner+1 mod N.
- Not defined: fixed priority, lowest index wins. The pointer register is absent. A continuously requesting requester 0 starves the others; this is accepted behaviour.

## Structure
- Package i2c_arb_pkg: state enum (IDLE, ISSUE, BUSY, DONE), WR=1'b0 and RD=1'b1 constants, a max-N constant.
- Sub-module i2c_rr_pick: combinational winner select from request vector and pointer. It outputs a one-hot grant and an index. With the macro undefined it is a fixed-priority encoder.

## Test plan
- Single requester 2 read addr 0x10, controller model returns 0x5A after 40 cycles -> s_ready[2] once, m_addr=0x10, m_direct=1, s_done[2] once with s_rdata=0x5A, txn_cnt=1.
- m_ready held low 100 cycles after reset (controller init) with s_valid[0] high -> no s_ready or m_valid until m_ready rises, then grant within 1 cycle.
- All 4 requesters continuously valid, RR enabled -> grant order 0,1,2,3,0,...; fixed build -> requester 0 granted every transaction.
- Write from requester 1 (addr 0x03, din 0xA7) -> m_din=0xA7 and m_direct=0 stable from ISSUE to DONE; no other requester's s_done pulses.
- rst asserted in BUSY -> next cycle all outputs at reset values, no s_done; a fresh request afterwards completes normally.
- Preload txn_cnt at 0xFFFF with CNT_W=16 via 65535 short transactions, or force -> next completion gives txn_cnt=0x0000.
